// File: rtl/regfile_mp_if.sv
// Bus bundle for the multi-port register file: write ports, read ports and
// the destination-reservation request. Vectors are packed port-major, so
// port k occupies [k*W +: W] of each field.
interface regfile_mp_if #(
  parameter int WIDTH     = 32,
  parameter int ADDR_BITS = 5,
  parameter int NREAD     = 3,
  parameter int NWRITE    = 2
);

  // Writeback side (ALU / memory result ports)
  logic [NWRITE-1:0]           wr_en;
  logic [NWRITE*ADDR_BITS-1:0] wr_addr;
  logic [NWRITE*WIDTH-1:0]     wr_data;

  // Decode side: operand reads
  logic [NREAD*ADDR_BITS-1:0]  rd_addr;
  logic [NREAD*WIDTH-1:0]      rd_data;
  logic [NREAD-1:0]            rd_busy;

  // Decode side: reservation of an issuing instruction's destination
  logic                        rsv_en;
  logic [ADDR_BITS-1:0]        rsv_addr;

  // Pipeline side that issues requests and consumes read results
  modport master (
    output wr_en, wr_addr, wr_data,
    output rd_addr,
    output rsv_en, rsv_addr,
    input  rd_data, rd_busy
  );

  // Register file side
  modport slave (
    input  wr_en, wr_addr, wr_data,
    input  rd_addr,
    input  rsv_en, rsv_addr,
    output rd_data, rd_busy
  );

endinterface

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with a per-register busy scoreboard.
// Reads are combinational from stored state, optionally forwarding same-cycle
// write data; a busy bit per register tracks an outstanding producer between
// issue (reservation) and writeback (write).
module regfile_mp #(
  parameter int WIDTH     = 32,
  parameter int ADDR_BITS = 5,
  parameter int NREAD     = 3,  // 1..8
  parameter int NWRITE    = 2,  // 1 or 2; higher port index wins conflicts
  parameter int ZERO_REG  = 1,  // register 0 hardwired to zero, never busy
  parameter int BYPASS    = 1   // forward same-cycle write data to reads
) (
  input logic          clk,
  input logic          rst,
  regfile_mp_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_BITS;

  // Architectural state
  logic [WIDTH-1:0] bank_q [DEPTH];
  logic [WIDTH-1:0] bank_d [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  // Unpacked views of the write ports
  logic [ADDR_BITS-1:0] wr_addr_w [NWRITE];
  logic [WIDTH-1:0]     wr_data_w [NWRITE];
  logic [NWRITE-1:0]    wr_ok;    // write actually lands in the bank
  logic                 rsv_ok;   // reservation actually sets a busy bit

  // Unpacked views of the read ports
  logic [ADDR_BITS-1:0] rd_addr_w [NREAD];
  logic [NREAD*WIDTH-1:0] rd_data_pk;
  logic [NREAD-1:0]       rd_busy_pk;

  genvar gi;

  // Slice write ports; writes to r0 are dropped when it is hardwired to zero
  generate
    for (gi = 0; gi < NWRITE; gi++) begin : g_wport
      assign wr_addr_w[gi] = bus.wr_addr[gi*ADDR_BITS +: ADDR_BITS];
      assign wr_data_w[gi] = bus.wr_data[gi*WIDTH +: WIDTH];
      assign wr_ok[gi]     = bus.wr_en[gi] &&
                             !((ZERO_REG != 0) && (wr_addr_w[gi] == '0));
    end
  endgenerate

  assign rsv_ok = bus.rsv_en && !((ZERO_REG != 0) && (bus.rsv_addr == '0));

  // Next-state for bank and scoreboard. Ports are applied in ascending order
  // so the higher-numbered port overrides on an index conflict, and the
  // reservation is applied last so a newer producer keeps the register busy.
  always_comb begin
    bank_d = bank_q;
    busy_d = busy_q;
    for (int k = 0; k < NWRITE; k++) begin
      if (wr_ok[k]) begin
        bank_d[wr_addr_w[k]] = wr_data_w[k];
        busy_d[wr_addr_w[k]] = 1'b0;
      end
    end
    if (rsv_ok) begin
      busy_d[bus.rsv_addr] = 1'b1;
    end
  end

  // State registers; reset clears every entry and every busy bit and
  // overrides any write or reservation presented in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < DEPTH; j++) begin
        bank_q[j] <= '0;
      end
      busy_q <= '0;
    end else begin
      bank_q <= bank_d;
      busy_q <= busy_d;
    end
  end

  // Per-port read mux: stored value, then bypass, then hardwired zero on top
  generate
    for (gi = 0; gi < NREAD; gi++) begin : g_rport
      logic [WIDTH-1:0] val;
      logic             bsy;

      assign rd_addr_w[gi] = bus.rd_addr[gi*ADDR_BITS +: ADDR_BITS];

      // Resolve this port's data and busy flag; a matching same-cycle write
      // means the value is being delivered now, so it is no longer pending
      always_comb begin
        val = bank_q[rd_addr_w[gi]];
        bsy = busy_q[rd_addr_w[gi]];
        if (BYPASS != 0) begin
          for (int k = 0; k < NWRITE; k++) begin
            if (bus.wr_en[k] && (wr_addr_w[k] == rd_addr_w[gi])) begin
              val = wr_data_w[k];
              bsy = 1'b0;
            end
          end
        end
        if ((ZERO_REG != 0) && (rd_addr_w[gi] == '0)) begin
          val = '0;
          bsy = 1'b0;
        end
      end

      assign rd_data_pk[gi*WIDTH +: WIDTH] = val;
      assign rd_busy_pk[gi]                = bsy;
    end
  endgenerate

  assign bus.rd_data = rd_data_pk;
  assign bus.rd_busy = rd_busy_pk;

endmodule
